// File: rtl/can_fault_confinement.sv
// can_fault_confinement: CAN error counters, node state and bus-off recovery
module can_fault_confinement #(
  parameter int RECESSIVE_RUN = 11,
  parameter int RECOVERY_SEQS = 128,
  parameter int PASSIVE_LIMIT = 127
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Data,
  input  logic       i_sample,
  input  logic       i_form_monitor,
  input  logic       i_bit_monitor,
  input  logic       i_stuff_monitor,
  input  logic       i_crc_monitor,
  input  logic       i_ack_monitor,
  input  logic       i_transmitter,
  input  logic       i_frame_ok,
  output logic [8:0] o_tec,
  output logic [7:0] o_rec,
  output logic [1:0] o_state,
  output logic       o_error_event,
  output logic       o_bus_off
);
  typedef enum logic [1:0] {ACTIVE = 2'b00, PASSIVE = 2'b01, BUS_OFF = 2'b10} state_t;
  localparam logic [3:0] RUN_LAST = 4'(RECESSIVE_RUN - 1);
  localparam logic [7:0] SEQ_DONE = 8'(RECOVERY_SEQS);
  localparam logic [8:0] TEC_LIM  = 9'(PASSIVE_LIMIT);
  localparam logic [7:0] REC_LIM  = 8'(PASSIVE_LIMIT);
  state_t     state, state_nx;
  logic       err_any, err_prev, evt, bo;
  logic [3:0] run_cnt, run_nx;
  logic [7:0] seq_cnt, seq_nx, rec_nx;
  logic [8:0] tec_nx;
  assign err_any   = i_form_monitor | i_bit_monitor | i_stuff_monitor | i_crc_monitor | i_ack_monitor;
  assign bo        = state == BUS_OFF;
  assign evt       = err_any & ~err_prev & ~bo;
  assign o_state   = state;
  assign o_bus_off = bo;
  // next counters and state: recovery counting in bus-off, error/frame accounting otherwise
  always_comb begin
    tec_nx   = o_tec;
    rec_nx   = o_rec;
    run_nx   = run_cnt;
    seq_nx   = seq_cnt;
    state_nx = state;
    if (bo) begin
      if (i_sample) begin
        run_nx = (!i_Data || run_cnt == RUN_LAST) ? 4'd0 : run_cnt + 4'd1;
        seq_nx = (i_Data && run_cnt == RUN_LAST) ? seq_cnt + 8'd1 : seq_cnt;
      end
      if (seq_nx == SEQ_DONE) begin
        tec_nx   = 9'd0;
        rec_nx   = 8'd0;
        run_nx   = 4'd0;
        seq_nx   = 8'd0;
        state_nx = ACTIVE;
      end
    end else begin
      if (evt) begin
        if (i_transmitter) tec_nx = (o_tec > 9'd248) ? 9'd256 : o_tec + 9'd8;
        else rec_nx = (o_rec == 8'd255) ? 8'd255 : o_rec + 8'd1;
      end else if (i_frame_ok) begin
        if (i_transmitter) tec_nx = (o_tec == 9'd0) ? 9'd0 : o_tec - 9'd1;
        else rec_nx = (o_rec > REC_LIM) ? 8'd120 : (o_rec == 8'd0) ? 8'd0 : o_rec - 8'd1;
      end
      state_nx = tec_nx[8] ? BUS_OFF : (tec_nx > TEC_LIM || rec_nx > REC_LIM) ? PASSIVE : ACTIVE;
      if (state_nx == BUS_OFF) begin
        run_nx = 4'd0;
        seq_nx = 4'd0;
      end
    end
  end
  // state, counters and registered error pulse
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state         <= ACTIVE;
      o_tec         <= 9'd0;
      o_rec         <= 8'd0;
      run_cnt       <= 4'd0;
      seq_cnt       <= 8'd0;
      err_prev      <= 1'b0;
      o_error_event <= 1'b0;
    end else begin
      state         <= state_nx;
      o_tec         <= tec_nx;
      o_rec         <= rec_nx;
      run_cnt       <= run_nx;
      seq_cnt       <= seq_nx;
      err_prev      <= err_any;
      o_error_event <= evt;
    end
  end
endmodule

// File: tb/tb_can_fault_confinement.sv
// tb_can_fault_confinement: directed vector table plus multi-cycle corner sequences
module tb_can_fault_confinement;
  logic       i_Clock = 0, i_Reset_n = 0, i_Data = 1, i_sample = 0;
  logic       i_form_monitor = 0, i_bit_monitor = 0, i_stuff_monitor = 0, i_crc_monitor = 0, i_ack_monitor = 0;
  logic       i_transmitter = 0, i_frame_ok = 0;
  logic [8:0] o_tec;
  logic [7:0] o_rec;
  logic [1:0] o_state;
  logic       o_error_event, o_bus_off;
  int         n_chk = 0, n_fail = 0;

  can_fault_confinement dut (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Data(i_Data), .i_sample(i_sample),
    .i_form_monitor(i_form_monitor), .i_bit_monitor(i_bit_monitor), .i_stuff_monitor(i_stuff_monitor),
    .i_crc_monitor(i_crc_monitor), .i_ack_monitor(i_ack_monitor), .i_transmitter(i_transmitter),
    .i_frame_ok(i_frame_ok), .o_tec(o_tec), .o_rec(o_rec), .o_state(o_state),
    .o_error_event(o_error_event), .o_bus_off(o_bus_off)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {
    logic [4:0] flags;
    logic       tx;
    logic       fok;
    logic [8:0] tec;
    logic [7:0] rec;
    logic [1:0] st;
    logic       ev;
  } vec_t;
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic do_reset();
    i_Reset_n = 0;
    #3;
    i_Reset_n = 1;
    tick();
  endtask

  task automatic pulse_err(input logic tx);
    i_transmitter = tx;
    i_ack_monitor = 1;
    tick();
    i_ack_monitor = 0;
    tick();
  endtask

  task automatic samp(input logic d);
    i_Data = d;
    i_sample = 1;
    tick();
    i_sample = 0;
  endtask

  task automatic rec_seqs(input int n);
    repeat (n * 11) samp(1);
  endtask

  task automatic to_bus_off();
    do_reset();
    repeat (32) pulse_err(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    //                 flags     tx fok  tec     rec    st    ev
    vecs[0]  = '{5'b00000, 0, 0, 9'd0,  8'd0, 2'd0, 0};
    vecs[1]  = '{5'b10000, 0, 0, 9'd0,  8'd1, 2'd0, 1};
    vecs[2]  = '{5'b10010, 0, 0, 9'd0,  8'd1, 2'd0, 0};
    vecs[3]  = '{5'b00000, 0, 0, 9'd0,  8'd1, 2'd0, 0};
    vecs[4]  = '{5'b01101, 0, 0, 9'd0,  8'd2, 2'd0, 1};
    vecs[5]  = '{5'b00000, 0, 1, 9'd0,  8'd1, 2'd0, 0};
    vecs[6]  = '{5'b00000, 0, 1, 9'd0,  8'd0, 2'd0, 0};
    vecs[7]  = '{5'b00000, 0, 1, 9'd0,  8'd0, 2'd0, 0};
    vecs[8]  = '{5'b00001, 1, 0, 9'd8,  8'd0, 2'd0, 1};
    vecs[9]  = '{5'b00000, 1, 1, 9'd7,  8'd0, 2'd0, 0};
    vecs[10] = '{5'b00100, 1, 1, 9'd15, 8'd0, 2'd0, 1};
    vecs[11] = '{5'b00000, 1, 1, 9'd14, 8'd0, 2'd0, 0};
    vecs[12] = '{5'b00010, 0, 1, 9'd14, 8'd1, 2'd0, 1};
    vecs[13] = '{5'b00000, 1, 1, 9'd13, 8'd1, 2'd0, 0};
    vecs[14] = '{5'b00000, 1, 1, 9'd12, 8'd1, 2'd0, 0};

    #12;
    chk("reset_tec", o_tec, 0);
    chk("reset_rec", o_rec, 0);
    chk("reset_state", o_state, 0);
    chk("reset_event", o_error_event, 0);
    chk("reset_bus_off", o_bus_off, 0);
    i_Reset_n = 1;
    tick();

    for (int i = 0; i < 15; i++) begin
      {i_form_monitor, i_bit_monitor, i_stuff_monitor, i_crc_monitor, i_ack_monitor} = vecs[i].flags;
      i_transmitter = vecs[i].tx;
      i_frame_ok = vecs[i].fok;
      tick();
      chk($sformatf("vec%0d_tec", i), o_tec, vecs[i].tec);
      chk($sformatf("vec%0d_rec", i), o_rec, vecs[i].rec);
      chk($sformatf("vec%0d_state", i), o_state, vecs[i].st);
      chk($sformatf("vec%0d_event", i), o_error_event, vecs[i].ev);
    end
    {i_form_monitor, i_bit_monitor, i_stuff_monitor, i_crc_monitor, i_ack_monitor} = 5'b0;
    i_frame_ok = 0;

    do_reset();
    i_transmitter = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      i_form_monitor = i < 10;
      i_crc_monitor = i >= 5 && i < 10;
      tick();
      pulses += int'(o_error_event);
    end
    chk("edge_pulses", pulses, 1);
    chk("edge_rec", o_rec, 1);

    do_reset();
    i_transmitter = 1;
    i_frame_ok = 1;
    i_ack_monitor = 1;
    tick();
    i_frame_ok = 0;
    i_ack_monitor = 0;
    tick();
    i_frame_ok = 1;
    i_crc_monitor = 1;
    tick();
    i_frame_ok = 0;
    i_crc_monitor = 0;
    tick();
    chk("collision_tec", o_tec, 16);

    do_reset();
    repeat (15) pulse_err(1);
    chk("esc15_tec", o_tec, 120);
    chk("esc15_state", o_state, 0);
    pulse_err(1);
    chk("esc16_tec", o_tec, 128);
    chk("esc16_state", o_state, 1);
    repeat (16) pulse_err(1);
    chk("esc32_tec", o_tec, 256);
    chk("esc32_state", o_state, 2);
    chk("esc32_bus_off", o_bus_off, 1);
    i_ack_monitor = 1;
    i_frame_ok = 1;
    tick();
    chk("busoff_no_event", o_error_event, 0);
    chk("busoff_tec_hold", o_tec, 256);
    i_ack_monitor = 0;
    i_frame_ok = 0;
    tick();

    repeat (128 * 11 - 1) samp(1);
    chk("recov_almost_state", o_state, 2);
    samp(1);
    chk("recov_state", o_state, 0);
    chk("recov_bus_off", o_bus_off, 0);
    chk("recov_tec", o_tec, 0);
    chk("recov_rec", o_rec, 0);

    do_reset();
    repeat (130) pulse_err(0);
    chk("rec130", o_rec, 130);
    chk("rec130_state", o_state, 1);
    i_transmitter = 0;
    i_frame_ok = 1;
    tick();
    i_frame_ok = 0;
    chk("rec_to_120", o_rec, 120);
    chk("rec_to_120_state", o_state, 0);

    to_bus_off();
    rec_seqs(49);
    repeat (9) samp(1);
    samp(0);
    rec_seqs(78);
    repeat (10) samp(1);
    chk("dominant_still_off", o_state, 2);
    samp(1);
    chk("dominant_recov_state", o_state, 0);
    chk("dominant_recov_tec", o_tec, 0);

    to_bus_off();
    rec_seqs(100);
    i_Reset_n = 0;
    #1;
    chk("async_tec", o_tec, 0);
    chk("async_state", o_state, 0);
    chk("async_bus_off", o_bus_off, 0);
    chk("async_event", o_error_event, 0);
    #2;
    i_Reset_n = 1;
    tick();
    rec_seqs(128);
    chk("post_reset_state", o_state, 0);
    chk("post_reset_tec", o_tec, 0);
    chk("post_reset_rec", o_rec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
